// File: rtl/sigmoid_pwl_pkg.sv
// Shared constants and types for the piecewise-linear sigmoid datapath.
package sigmoid_pwl_pkg;

  // Which linear piece of the approximation a magnitude falls into
  typedef enum logic [1:0] {
    SEG_LOW  = 2'd0,  // a < 1.0
    SEG_MID  = 2'd1,  // 1.0 <= a < 2.375
    SEG_HIGH = 2'd2,  // 2.375 <= a < 5.0
    SEG_SAT  = 2'd3   // a >= 5.0
  } seg_e;

  // 1.0 in Q.FRAC
  function automatic int unsigned pwl_one(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // 0.5 in Q.FRAC
  function automatic int unsigned pwl_half(input int unsigned frac);
    return 32'd1 << (frac - 32'd1);
  endfunction

  // 0.625 offset of the middle segment
  function automatic int unsigned pwl_ofs1(input int unsigned frac);
    return 32'd5 << (frac - 32'd3);
  endfunction

  // 0.84375 offset of the upper segment
  function automatic int unsigned pwl_ofs2(input int unsigned frac);
    return 32'd27 << (frac - 32'd5);
  endfunction

  // Breakpoint 1.0
  function automatic int unsigned pwl_bp1(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // Breakpoint 2.375
  function automatic int unsigned pwl_bp2(input int unsigned frac);
    return 32'd19 << (frac - 32'd3);
  endfunction

  // Breakpoint 5.0
  function automatic int unsigned pwl_bp3(input int unsigned frac);
    return 32'd5 << frac;
  endfunction

endpackage

// File: rtl/sigmoid_pwl_pipe_segment_eval.sv
// Combinational PLAN evaluation of f(a) for a non-negative magnitude a.
module pwl_segment_eval
  import sigmoid_pwl_pkg::*;
#(
  parameter int unsigned BITS = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic [BITS-1:0] a,
  output logic [BITS-1:0] y_c
);

  localparam logic [BITS-1:0] ONE_V  = BITS'(pwl_one(FRAC));
  localparam logic [BITS-1:0] HALF_V = BITS'(pwl_half(FRAC));
  localparam logic [BITS-1:0] OFS1_V = BITS'(pwl_ofs1(FRAC));
  localparam logic [BITS-1:0] OFS2_V = BITS'(pwl_ofs2(FRAC));
  localparam logic [BITS-1:0] BP1_V  = BITS'(pwl_bp1(FRAC));
  localparam logic [BITS-1:0] BP2_V  = BITS'(pwl_bp2(FRAC));
  localparam logic [BITS-1:0] BP3_V  = BITS'(pwl_bp3(FRAC));

  seg_e seg_c;

  // Classify the magnitude; a breakpoint value belongs to the upper piece
  always_comb begin
    seg_c = SEG_LOW;
    if (a >= BP3_V)      seg_c = SEG_SAT;
    else if (a >= BP2_V) seg_c = SEG_HIGH;
    else if (a >= BP1_V) seg_c = SEG_MID;
  end

  // Evaluate the selected piece; the result never exceeds 1.0
  always_comb begin
    y_c = ONE_V;
    case (seg_c)
      SEG_LOW:  y_c = (a >> 2) + HALF_V;
      SEG_MID:  y_c = (a >> 3) + OFS1_V;
      SEG_HIGH: y_c = (a >> 5) + OFS2_V;
      SEG_SAT:  y_c = ONE_V;
      default:  y_c = ONE_V;
    endcase
  end

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage streaming sigmoid: |x| capture, PWL evaluation, sign mirror.
module sigmoid_pwl_pipe
  import sigmoid_pwl_pkg::*;
#(
  parameter int unsigned BITS = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            busy
);

  localparam logic [BITS-1:0] ONE_V   = BITS'(pwl_one(FRAC));
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] MAX_POS = {1'b0, {(BITS-1){1'b1}}};

  logic            advance_c;
  logic [BITS-1:0] abs_c;
  logic [BITS-1:0] y_c;

  logic            v1, v2, v3;
  logic            sign1, sign2;
  logic [BITS-1:0] a1;
  logic [BITS-1:0] y2;

  // Whole pipe moves only when the output slot is empty or being drained
  assign advance_c = !v3 || out_ready;
  assign in_ready  = advance_c;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  // Magnitude with the most-negative code clamped to the largest positive
  always_comb begin
    abs_c = in_data;
    if (in_data[BITS-1]) begin
      if (in_data == MIN_NEG) abs_c = MAX_POS;
      else                    abs_c = ~in_data + BITS'(1);
    end
  end

  pwl_segment_eval #(
    .BITS (BITS),
    .FRAC (FRAC)
  ) u_eval (
    .a   (a1),
    .y_c (y_c)
  );

  // Lock-step pipeline registers; everything holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      a1       <= '0;
      y2       <= '0;
      out_data <= '0;
    end else if (advance_c) begin
      v1       <= in_valid;
      sign1    <= in_data[BITS-1];
      a1       <= abs_c;
      v2       <= v1;
      sign2    <= sign1;
      y2       <= y_c;
      v3       <= v2;
      out_data <= sign2 ? (ONE_V - y2) : y2;
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Self-checking bench for sigmoid_pwl_pipe (BITS=16, FRAC=8).
module tb_sigmoid_pwl_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [15:0] sb_q[$];
  logic        hold_valid = 1'b0;
  logic [15:0] hold_data = '0;

  sigmoid_pwl_pipe #(.BITS(16), .FRAC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sigmoid from the segment table, evaluated on the real-valued magnitude
  function automatic logic [15:0] model(input logic [15:0] x);
    int  xs;
    int  a;
    int  y;
    real ar;
    xs = int'($signed(x));
    a  = (xs < 0) ? -xs : xs;
    if (a > 32767) a = 32767;
    ar = a / 256.0;
    if (ar >= 5.0)        y = 256;
    else if (ar >= 2.375) y = a / 32 + $rtoi(0.84375 * 256.0);
    else if (ar >= 1.0)   y = a / 8 + $rtoi(0.625 * 256.0);
    else                  y = a / 4 + $rtoi(0.5 * 256.0);
    return (xs < 0) ? 16'(256 - y) : 16'(y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle, records transfers happening at the next rising edge
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      hold_valid = 1'b0;
    end else begin
      chk("busy_vs_inflight", 32'(busy), 32'(sb_q.size() != 0));
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_valid) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_data_held", 32'(out_data), 32'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        else                  chk("stream_data", 32'(out_data), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_data));
        acc_cnt++;
      end
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
    end
  end

  // One isolated sample: latency counted in rising edges from the capturing edge
  task automatic send_check(input logic [15:0] x, input logic [15:0] exp);
    int cyc;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd3);
    chk("single_data", 32'(out_data), 32'(exp));
  endtask

  logic [15:0] dir_x[9] = '{16'h0000, 16'h0080, 16'h0100, 16'hFF00, 16'h0600,
                            16'hFA00, 16'h8000, 16'h0300, 16'h0260};
  // 2.375 sits in the upper piece: 608/32 + 216 = 235
  logic [15:0] dir_y[9] = '{16'h0080, 16'h00A0, 16'h00C0, 16'h0040, 16'h0100,
                            16'h0000, 16'h0000, 16'h00F0, 16'h00EB};

  initial begin
    int n_valid;
    int cyc;
    int start;
    logic [15:0] held;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", 32'(out_data), 32'd0);
    #9 rst = 1'b0;

    // Directed single samples, saturation and breakpoints
    for (int i = 0; i < 9; i++) begin
      send_check(dir_x[i], dir_y[i]);
      chk("model_agrees", 32'(out_data), 32'(model(dir_x[i])));
    end

    // Back-to-back stream of 8
    n_valid = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (out_valid) n_valid++;
      if (i >= 3 && i <= 10) chk("b2b_consecutive", 32'(out_valid), 32'd1);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      in_valid  = (i < 8);
      in_data   = 16'($urandom_range(0, 3200)) - 16'd1600;
      out_ready = 1'b1;
    end
    chk("b2b_count", 32'(n_valid), 32'd8);

    // Back-pressure: out_ready low for 5 cycles mid-stream
    held = '0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i >= 5 && i <= 9) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (i == 5) held = out_data;
      if (i > 5 && i <= 9) chk("bp_data_stable", 32'(out_data), 32'(held));
      in_valid  = (i < 12);
      in_data   = 16'($urandom);
      out_ready = !(i >= 4 && i < 9);
    end

    // Random traffic, 50% valid / 50% ready
    start = acc_cnt;
    cyc = 0;
    while ((acc_cnt - start) < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 3200)) - 16'd1600;
      out_ready = ($urandom_range(0, 1) == 1);
      cyc++;
    end
    chk("random_budget", 32'(cyc < 20000), 32'd1);

    // Drain
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      out_ready = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    #8 rst = 1'b0;
    out_ready = 1'b1;
    send_check(16'h0100, 16'h00C0);
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
